// File: rtl/tpram_rd_seq_pkg.sv
// -----------------------------------------------------------------------------
// tpram_rd_pkg
// Shared types and constants for the TPRAM read-side streaming sequencer.
//   rd_state_t     : sequencer FSM states (IDLE, RUN, DRAIN)
//   FIFO_DEPTH     : depth of the {last, data} return buffer
//   FIFO_CNT_W     : width of the buffer occupancy count
//   WORD_OFS_MASK  : byte-offset bits of a 32-bit word address, cleared on use
// -----------------------------------------------------------------------------
package tpram_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_t;

    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W = 2;

    // Low address bits that select a byte inside a 32-bit word.
    localparam logic [1:0] WORD_OFS_MASK = 2'b11;

endpackage

// File: rtl/tpram_rd_seq_if.sv
// -----------------------------------------------------------------------------
// tpram_rd_seq_if
// Valid/ready stream carrying TPRAM read words to the math block.
//   m_valid : word available (held until accepted)
//   m_data  : DATA_W-bit word
//   m_last  : final word of the transfer
//   m_ready : consumer accepts the word this cycle
// Modports: master (sequencer side), slave (math-block side).
// -----------------------------------------------------------------------------
interface tpram_rd_seq_if #(
    parameter int DATA_W = 32
);
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/tpram_rd_seq_fifo2.sv
// -----------------------------------------------------------------------------
// tpram_rd_fifo2
// Two-entry {last, data} FIFO. The head entry lives in registers that drive
// the stream outputs directly, so nothing downstream sees combinational paths.
//   EFPGA_TPRAM_R_CLK : clock
//   r_addr_ff_rstn    : asynchronous active-low reset
//   flush             : synchronous empty (contents discarded)
//   push/push_last/push_data : write port (caller guarantees room)
//   pop               : remove head (caller only pops when out_valid)
//   cnt               : current occupancy
//   out_valid/out_data/out_last : registered head entry
// -----------------------------------------------------------------------------
module tpram_rd_fifo2
    import tpram_rd_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  EFPGA_TPRAM_R_CLK,
    input  logic                  r_addr_ff_rstn,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  push_last,
    input  logic [DATA_W-1:0]     push_data,
    input  logic                  pop,
    output logic [FIFO_CNT_W-1:0] cnt,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_last
);

    localparam logic [FIFO_CNT_W-1:0] CNT_EMPTY = '0;
    localparam logic [FIFO_CNT_W-1:0] CNT_ONE   = FIFO_CNT_W'(1);
    localparam logic [FIFO_CNT_W-1:0] CNT_FULL  = FIFO_CNT_W'(FIFO_DEPTH);

    logic [FIFO_CNT_W-1:0] r_cnt;
    logic                  r_valid;
    logic                  r_head_last;
    logic [DATA_W-1:0]     r_head_data;
    logic                  r_tail_last;
    logic [DATA_W-1:0]     r_tail_data;

    logic                  w_head_from_in;
    logic                  w_head_from_tail;
    logic                  w_tail_from_in;
    logic [FIFO_CNT_W-1:0] w_cnt_next;

    always_comb begin
        // Incoming word goes straight to the head when the head is free
        // (empty, or being popped with nothing behind it).
        w_head_from_in   = push && ((r_cnt == CNT_EMPTY) || ((r_cnt == CNT_ONE) && pop));
        w_head_from_tail = pop && (r_cnt == CNT_FULL);
        w_tail_from_in   = push && (((r_cnt == CNT_ONE) && !pop) || ((r_cnt == CNT_FULL) && pop));
        w_cnt_next       = r_cnt + FIFO_CNT_W'(push) - FIFO_CNT_W'(pop);
    end

    always_ff @(posedge EFPGA_TPRAM_R_CLK or negedge r_addr_ff_rstn) begin
        if (!r_addr_ff_rstn) begin
            r_cnt       <= CNT_EMPTY;
            r_valid     <= 1'b0;
            r_head_last <= 1'b0;
            r_head_data <= '0;
            r_tail_last <= 1'b0;
            r_tail_data <= '0;
        end else if (flush) begin
            r_cnt   <= CNT_EMPTY;
            r_valid <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_valid <= (w_cnt_next != CNT_EMPTY);
            if (w_head_from_in) begin
                r_head_last <= push_last;
                r_head_data <= push_data;
            end else if (w_head_from_tail) begin
                r_head_last <= r_tail_last;
                r_head_data <= r_tail_data;
            end
            if (w_tail_from_in) begin
                r_tail_last <= push_last;
                r_tail_data <= push_data;
            end
        end
    end

    assign cnt       = r_cnt;
    assign out_valid = r_valid;
    assign out_data  = r_head_data;
    assign out_last  = r_head_last;

endmodule

// File: rtl/tpram_rd_seq.sv
// -----------------------------------------------------------------------------
// tpram_rd_seq
// Read-side streaming sequencer for the 512x64 math-unit TPRAM. Walks a
// strided word-address sequence on the TPRAM read port, captures each word
// one cycle after its address was sampled, and hands the words to the math
// block as a valid/ready stream with a last flag.
//   EFPGA_TPRAM_R_CLK : clock
//   r_addr_ff_rstn    : asynchronous active-low reset
//   start             : transfer request, honoured only in IDLE
//   abort             : synchronous flush back to IDLE (no done)
//   base_addr/stride  : first byte address / byte increment (word aligned)
//   count             : number of words (0 completes immediately)
//   tpram_rdata       : TPRAM read data (TPRAM_MATHB_R_DATA)
//   tpram_raddr       : registered TPRAM read address (EFPGA_TPRAM_R_ADDR)
//   m_if              : output stream (master side)
//   busy              : transfer in progress (RUN or DRAIN)
//   done              : one-cycle pulse after the last word is accepted
// -----------------------------------------------------------------------------
module tpram_rd_seq
    import tpram_rd_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 11
) (
    input  logic              EFPGA_TPRAM_R_CLK,
    input  logic              r_addr_ff_rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic [CNT_W-1:0]  count,
    input  logic [DATA_W-1:0] tpram_rdata,
    output logic [ADDR_W-1:0] tpram_raddr,
    tpram_rd_seq_if.master    m_if,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0]     ALIGN_MASK = ~ADDR_W'(WORD_OFS_MASK);
    localparam logic [FIFO_CNT_W-1:0] CNT_FULL   = FIFO_CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);

    rd_state_t         r_state,  w_state_next;
    logic [ADDR_W-1:0] r_raddr,  w_raddr_next;
    logic [ADDR_W-1:0] r_stride, w_stride_next;
    logic [CNT_W-1:0]  r_rem,    w_rem_next;
    // r_issued: tpram_raddr was loaded at the last edge; its word appears on
    // tpram_rdata next cycle.
    logic              r_issued, w_issued_next;
    logic              r_issued_last, w_issued_last_next;
    // r_inflight: tpram_rdata carries a word that has not been captured yet.
    logic              r_inflight, w_inflight_next;
    logic              r_inflight_last, w_inflight_last_next;
    logic              r_done, w_done_next;

    logic [FIFO_CNT_W-1:0] w_fifo_cnt;
    logic                  w_fifo_valid;
    logic [DATA_W-1:0]     w_fifo_data;
    logic                  w_fifo_last;
    logic                  w_pop;
    logic                  w_capture;
    logic [2:0]            w_occ;
    logic                  w_room;

    always_comb begin
        w_pop  = w_fifo_valid & m_if.m_ready;
        w_occ  = 3'(w_fifo_cnt) + 3'(r_inflight) - 3'(w_pop);
        // Issuing now puts a word on tpram_rdata two cycles from now; it must
        // be capturable then even with no further pops, hence occupancy <= 1.
        w_room = (w_occ < 3'd2);
        // With no issue at the last edge the address has been held, so an
        // uncaptured word stays on tpram_rdata and capture may wait for room.
        w_capture = r_inflight && ((w_fifo_cnt < CNT_FULL) || w_pop) && !abort;
    end

    always_comb begin
        w_state_next         = r_state;
        w_raddr_next         = r_raddr;
        w_stride_next        = r_stride;
        w_rem_next           = r_rem;
        w_issued_next        = 1'b0;
        w_issued_last_next   = 1'b0;
        w_inflight_next      = r_inflight;
        w_inflight_last_next = r_inflight_last;
        w_done_next          = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        w_raddr_next       = base_addr & ALIGN_MASK;
                        w_stride_next      = stride & ALIGN_MASK;
                        w_rem_next         = count - CNT_ONE;
                        w_issued_next      = 1'b1;
                        w_issued_last_next = (count == CNT_ONE);
                        w_state_next       = ST_RUN;
                    end else begin
                        w_done_next = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (r_rem == '0) begin
                    w_state_next = ST_DRAIN;
                end else if (w_room) begin
                    w_raddr_next       = r_raddr + r_stride;
                    w_rem_next         = r_rem - CNT_ONE;
                    w_issued_next      = 1'b1;
                    w_issued_last_next = (r_rem == CNT_ONE);
                end
            end
            ST_DRAIN: begin
                if (w_pop && w_fifo_last) begin
                    w_done_next  = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (r_issued) begin
            w_inflight_next      = 1'b1;
            w_inflight_last_next = r_issued_last;
        end else if (w_capture) begin
            w_inflight_next      = 1'b0;
            w_inflight_last_next = 1'b0;
        end

        // Abort overrides everything; the address is deliberately left alone.
        if (abort) begin
            w_state_next         = ST_IDLE;
            w_raddr_next         = r_raddr;
            w_stride_next        = r_stride;
            w_rem_next           = r_rem;
            w_issued_next        = 1'b0;
            w_issued_last_next   = 1'b0;
            w_inflight_next      = 1'b0;
            w_inflight_last_next = 1'b0;
            w_done_next          = 1'b0;
        end
    end

    always_ff @(posedge EFPGA_TPRAM_R_CLK or negedge r_addr_ff_rstn) begin
        if (!r_addr_ff_rstn) begin
            r_state         <= ST_IDLE;
            r_raddr         <= '0;
            r_stride        <= '0;
            r_rem           <= '0;
            r_issued        <= 1'b0;
            r_issued_last   <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_raddr         <= w_raddr_next;
            r_stride        <= w_stride_next;
            r_rem           <= w_rem_next;
            r_issued        <= w_issued_next;
            r_issued_last   <= w_issued_last_next;
            r_inflight      <= w_inflight_next;
            r_inflight_last <= w_inflight_last_next;
            r_done          <= w_done_next;
        end
    end

    tpram_rd_fifo2 #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .EFPGA_TPRAM_R_CLK (EFPGA_TPRAM_R_CLK),
        .r_addr_ff_rstn    (r_addr_ff_rstn),
        .flush             (abort),
        .push              (w_capture),
        .push_last         (r_inflight_last),
        .push_data         (tpram_rdata),
        .pop               (w_pop),
        .cnt               (w_fifo_cnt),
        .out_valid         (w_fifo_valid),
        .out_data          (w_fifo_data),
        .out_last          (w_fifo_last)
    );

    assign tpram_raddr  = r_raddr;
    assign m_if.m_valid = w_fifo_valid;
    assign m_if.m_data  = w_fifo_data;
    assign m_if.m_last  = w_fifo_last;
    assign busy         = (r_state != ST_IDLE);
    assign done         = r_done;

endmodule

// File: tb/tb_tpram_rd_seq.sv
`timescale 1ns/1ps
module tb_tpram_rd_seq;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        abort;
    logic [11:0] base_addr;
    logic [11:0] stride;
    logic [10:0] count;
    logic [31:0] tpram_rdata;
    logic [11:0] tpram_raddr;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tpram_rd_seq_if #(.DATA_W(32)) m_if ();

    tpram_rd_seq #(
        .ADDR_W (12),
        .DATA_W (32),
        .CNT_W  (11)
    ) dut (
        .EFPGA_TPRAM_R_CLK (clk),
        .r_addr_ff_rstn    (rstn),
        .start             (start),
        .abort             (abort),
        .base_addr         (base_addr),
        .stride            (stride),
        .count             (count),
        .tpram_rdata       (tpram_rdata),
        .tpram_raddr       (tpram_raddr),
        .m_if              (m_if),
        .busy              (busy),
        .done              (done)
    );

    // Memory contents: each word encodes its own byte address.
    function automatic logic [31:0] word_at(input logic [11:0] a);
        return {8'hD7, ~a, a};
    endfunction

    // Synchronous-read TPRAM model: data one cycle after the address.
    always @(posedge clk) tpram_rdata <= word_at({tpram_raddr[11:2], 2'b00});

    function automatic logic [11:0] exp_addr(input logic [11:0] b, input logic [11:0] s, input int k);
        return (b & 12'hFFC) + 12'(k) * (s & 12'hFFC);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [11:0] base;
        logic [11:0] strd;
        int          cnt;
        logic [31:0] ready_mask;   // m_ready in cycle c = bit c (1 beyond bit 31)
        int          poke_start;   // cycle to pulse a stray start (0 = none)
        int          n_addr_chk;   // cycles 1..n where tpram_raddr must step every cycle
        int          exp_first;    // cycle of first accepted beat (0 = unchecked)
        int          exp_last;     // cycle of last accepted beat (0 = unchecked)
        int          exp_done;     // cycle of done pulse (0 = unchecked)
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v);
        int beats    = 0;
        int done_cnt = 0;
        int done_cyc = -1;
        int first    = -1;
        int last     = -1;
        int c        = 0;
        @(posedge clk); #1;
        base_addr = v.base; stride = v.strd; count = 11'(v.cnt);
        start = 1'b1; m_if.m_ready = v.ready_mask[0];
        while (c < 80 && !(done_cnt > 0 && c > done_cyc + 2)) begin
            if (c > 0) begin
                @(posedge clk); #1;
                start = (c == v.poke_start);
                if (start) begin
                    base_addr = 12'h300; count = 11'd2;
                end else begin
                    base_addr = v.base; count = 11'(v.cnt);
                end
                m_if.m_ready = (c < 32) ? v.ready_mask[c] : 1'b1;
            end
            @(negedge clk);
            if (c >= 1 && c <= v.n_addr_chk)
                chk($sformatf("%s raddr c%0d", v.name, c), 64'(tpram_raddr),
                    64'(exp_addr(v.base, v.strd, c - 1)));
            if (m_if.m_valid && m_if.m_ready) begin
                chk($sformatf("%s beat%0d data", v.name, beats), 64'(m_if.m_data),
                    64'(word_at(exp_addr(v.base, v.strd, beats))));
                chk($sformatf("%s beat%0d last", v.name, beats), 64'(m_if.m_last),
                    64'(beats == v.cnt - 1));
                if (first < 0) first = c;
                last = c;
                beats++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            c++;
        end
        m_if.m_ready = 1'b1; start = 1'b0;
        chk($sformatf("%s beat count", v.name), 64'(beats), 64'(v.cnt));
        chk($sformatf("%s done pulses", v.name), 64'(done_cnt), 64'd1);
        if (v.exp_first != 0) chk($sformatf("%s first beat cycle", v.name), 64'(first), 64'(v.exp_first));
        if (v.exp_last  != 0) chk($sformatf("%s last beat cycle", v.name), 64'(last), 64'(v.exp_last));
        if (v.exp_done  != 0) chk($sformatf("%s done cycle", v.name), 64'(done_cyc), 64'(v.exp_done));
        $display("vector %s: beats=%0d first=%0d last=%0d done=%0d", v.name, beats, first, last, done_cyc);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " raddr"},  64'(tpram_raddr),  64'd0);
        chk({tag, " m_valid"}, 64'(m_if.m_valid), 64'd0);
        chk({tag, " m_data"},  64'(m_if.m_data),  64'd0);
        chk({tag, " m_last"},  64'(m_if.m_last),  64'd0);
        chk({tag, " busy"},    64'(busy),         64'd0);
        chk({tag, " done"},    64'(done),         64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_valid;
        int seen_busy;
        int seen_done;

        vecs[0] = '{"basic",   12'h010, 12'd4,  4, 32'hFFFFFFFF, 0, 4, 3, 6, 7};
        vecs[1] = '{"backpr",  12'h010, 12'd4,  4, 32'hFFFFFF07, 0, 3, 8, 0, 0};
        vecs[2] = '{"wrap",    12'hFFC, 12'd8,  3, 32'hFFFFFFFF, 0, 3, 3, 5, 6};
        vecs[3] = '{"unalign", 12'h023, 12'd7,  2, 32'hFFFFFFFF, 0, 2, 3, 4, 5};
        vecs[4] = '{"single",  12'h100, 12'd4,  1, 32'hFFFFFFFF, 0, 1, 3, 3, 4};
        vecs[5] = '{"altrdy",  12'h200, 12'd12, 5, 32'hAAAAAAAA, 0, 2, 3, 0, 0};
        vecs[6] = '{"runpoke", 12'h010, 12'd4,  4, 32'hFFFFFFFF, 2, 4, 3, 6, 7};

        rstn = 1'b0; start = 1'b0; abort = 1'b0;
        base_addr = '0; stride = '0; count = '0; m_if.m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("post-reset busy", 64'(busy), 64'd0);
        chk("post-reset valid", 64'(m_if.m_valid), 64'd0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Zero count: done in cycle 1, nothing else moves.
        @(posedge clk); #1;
        base_addr = 12'h040; stride = 12'd4; count = 11'd0; start = 1'b1; m_if.m_ready = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        chk("zero done c1", 64'(done), 64'd1);
        seen_valid = int'(m_if.m_valid); seen_busy = int'(busy); seen_done = 0;
        for (int c = 2; c < 6; c++) begin
            @(negedge clk);
            seen_valid += int'(m_if.m_valid); seen_busy += int'(busy); seen_done += int'(done);
        end
        chk("zero valid seen", 64'(seen_valid), 64'd0);
        chk("zero busy seen", 64'(seen_busy), 64'd0);
        chk("zero extra done", 64'(seen_done), 64'd0);
        $display("sequence zero-count: valid=%0d busy=%0d", seen_valid, seen_busy);

        // Reset during cycle 4 of a count-8 run.
        @(posedge clk); #1;
        base_addr = 12'h040; stride = 12'd4; count = 11'd8; start = 1'b1; m_if.m_ready = 1'b1;
        for (int c = 1; c < 4; c++) begin
            @(posedge clk); #1; start = 1'b0;
        end
        @(posedge clk); #2; rstn = 1'b0;
        #1;
        chk_all_zero("midrun reset");
        @(negedge clk); rstn = 1'b1;
        seen_valid = 0; seen_busy = 0; seen_done = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            seen_valid += int'(m_if.m_valid); seen_busy += int'(busy); seen_done += int'(done);
        end
        chk("midrun post valid", 64'(seen_valid), 64'd0);
        chk("midrun post busy", 64'(seen_busy), 64'd0);
        chk("midrun post done", 64'(seen_done), 64'd0);
        $display("sequence reset-mid-run: done=%0d busy=%0d", seen_done, seen_busy);
        run_vec(vecs[0]);

        // Abort in DRAIN with two words buffered (count 2, no ready).
        @(posedge clk); #1;
        base_addr = 12'h080; stride = 12'd4; count = 11'd2; start = 1'b1; m_if.m_ready = 1'b0;
        for (int c = 1; c < 4; c++) begin
            @(posedge clk); #1; start = 1'b0;
        end
        @(posedge clk); #1; abort = 1'b1;
        @(negedge clk);
        chk("abort pre busy", 64'(busy), 64'd1);
        chk("abort pre valid", 64'(m_if.m_valid), 64'd1);
        chk("abort pre data", 64'(m_if.m_data), 64'(word_at(12'h080)));
        @(posedge clk); #1; abort = 1'b0; m_if.m_ready = 1'b1;
        @(negedge clk);
        chk("abort valid", 64'(m_if.m_valid), 64'd0);
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort raddr held", 64'(tpram_raddr), 64'h084);
        seen_valid = 0; seen_done = int'(done);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            seen_valid += int'(m_if.m_valid); seen_done += int'(done);
        end
        chk("abort later valid", 64'(seen_valid), 64'd0);
        chk("abort no done", 64'(seen_done), 64'd0);
        $display("sequence abort-drain: valid=%0d done=%0d", seen_valid, seen_done);

        // abort and start together in IDLE: abort wins.
        @(posedge clk); #1;
        base_addr = 12'h500; stride = 12'd4; count = 11'd3; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1; start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("abort+start busy", 64'(busy), 64'd0);
        chk("abort+start raddr", 64'(tpram_raddr), 64'h084);
        seen_valid = 0; seen_done = int'(done);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            seen_valid += int'(m_if.m_valid); seen_done += int'(done);
        end
        chk("abort+start valid", 64'(seen_valid), 64'd0);
        chk("abort+start done", 64'(seen_done), 64'd0);
        $display("sequence abort+start: busy=%0d", busy);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
